// File: rtl/memory_game_pkg.sv
// Shared types and constants for the button memory game round controller.
package memory_game_pkg;

    localparam int unsigned KEY_W    = 4;
    localparam int unsigned MAX_KEYS = 8;
    localparam int unsigned SEQ_W    = KEY_W * MAX_KEYS;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GEN     = 3'd1,
        ST_SHOW    = 3'd2,
        ST_INPUT   = 3'd3,
        ST_CHECK   = 3'd4,
        ST_SUCCESS = 3'd5,
        ST_FAIL    = 3'd6,
        ST_OVER    = 3'd7
    } state_e;

    // Ones in the low k nibbles, zeros above.
    function automatic logic [SEQ_W-1:0] key_mask(input logic [KEY_W-1:0] k);
        logic [SEQ_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (KEY_W'(i) < k) m[i*KEY_W +: KEY_W] = '1;
        end
        return m;
    endfunction

endpackage

// File: rtl/memory_game_ctrl_lfsr.sv
// Free-running 16-bit Galois LFSR; presents the next key value (1..8).
module game_lfsr16
    import memory_game_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic             clk,
    input  logic             rst,
    output logic [KEY_W-1:0] key_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign key_o = KEY_W'(lfsr_q[2:0]) + KEY_W'(1);

endmodule

// File: rtl/memory_game_ctrl.sv
// Round controller: generates, shows and checks key sequences; tracks level, lives and score.
module memory_game_ctrl
    import memory_game_pkg::*;
#(
    parameter int unsigned STEP_CYCLES    = 25000000,
    parameter int unsigned TIMEOUT_CYCLES = 250000000,
    parameter int unsigned RESULT_CYCLES  = 50000000,
    parameter int unsigned START_LEVEL    = 3,
    parameter int unsigned MAX_LEVEL      = 8,
    parameter int unsigned LIVES_INIT     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_pulse,
    input  logic             input_done,
    input  logic [SEQ_W-1:0] user_seq,
    output logic             enable_input,
    output logic             start_clear,
    output logic [KEY_W-1:0] difficulty_k,
    output logic             time_up,
    output logic [KEY_W-1:0] show_key,
    output logic [2:0]       state_o,
    output logic [1:0]       lives,
    output logic [7:0]       score,
    output logic             win,
    output logic             game_over
);

    localparam int unsigned TMR_MAX =
        (STEP_CYCLES > TIMEOUT_CYCLES)
            ? ((STEP_CYCLES > RESULT_CYCLES) ? STEP_CYCLES : RESULT_CYCLES)
            : ((TIMEOUT_CYCLES > RESULT_CYCLES) ? TIMEOUT_CYCLES : RESULT_CYCLES);
    localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] STEP_LAST    = TMR_W'(STEP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] RESULT_LAST  = TMR_W'(RESULT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [2:0]         key_idx_q, key_idx_d;
    logic               gap_q, gap_d;
    logic [SEQ_W-1:0]   target_q, target_d;
    logic [KEY_W-1:0]   level_q, level_d;
    logic [1:0]         lives_q, lives_d;
    logic [7:0]         score_q, score_d;
    logic               win_q, win_d;
    logic               game_over_q, game_over_d;
    logic               timeout_q, timeout_d;
    logic               enable_q, enable_d;
    logic               start_clear_q, start_clear_d;
    logic               time_up_q, time_up_d;
    logic [KEY_W-1:0]   show_key_q, show_key_d;
    logic [KEY_W-1:0]   lfsr_key;
    logic               first_input_c;

    game_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .key_o (lfsr_key)
    );

    // The timer sits at 0 with time_up low only on the first INPUT cycle.
    assign first_input_c = (tmr_q == '0) && !time_up_q;

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        key_idx_d     = key_idx_q;
        gap_d         = gap_q;
        target_d      = target_q;
        level_d       = level_q;
        lives_d       = lives_q;
        score_d       = score_q;
        win_d         = win_q;
        game_over_d   = game_over_q;
        timeout_d     = timeout_q;
        start_clear_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_pulse) begin
                    start_clear_d = 1'b1;
                    lives_d       = 2'(LIVES_INIT);
                    score_d       = '0;
                    level_d       = KEY_W'(START_LEVEL);
                    win_d         = 1'b0;
                    game_over_d   = 1'b0;
                    key_idx_d     = '0;
                    state_d       = ST_GEN;
                end
            end
            ST_GEN: begin
                target_d[{key_idx_q, 2'b00} +: KEY_W] =
                    ({1'b0, key_idx_q} < level_q) ? lfsr_key : '0;
                key_idx_d = key_idx_q + 3'd1;
                if (key_idx_q == 3'd7) begin
                    state_d   = ST_SHOW;
                    key_idx_d = '0;
                    gap_d     = 1'b0;
                    tmr_d     = '0;
                end
            end
            ST_SHOW: begin
                if (tmr_q == STEP_LAST) begin
                    tmr_d = '0;
                    if (!gap_q) begin
                        gap_d = 1'b1;
                    end else if ({1'b0, key_idx_q} == level_q - KEY_W'(1)) begin
                        state_d = ST_INPUT;
                    end else begin
                        key_idx_d = key_idx_q + 3'd1;
                        gap_d     = 1'b0;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_INPUT: begin
                if (input_done && !first_input_c) begin
                    timeout_d = time_up_q;
                    state_d   = ST_CHECK;
                end else if (tmr_q != TIMEOUT_LAST) begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_CHECK: begin
                tmr_d = '0;
                if (!timeout_q && (((user_seq ^ target_q) & key_mask(level_q)) == '0)) begin
                    state_d = ST_SUCCESS;
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                end else begin
                    state_d = ST_FAIL;
                    lives_d = lives_q - 2'd1;
                end
            end
            ST_SUCCESS: begin
                if (tmr_q == RESULT_LAST) begin
                    tmr_d     = '0;
                    key_idx_d = '0;
                    if (level_q == KEY_W'(MAX_LEVEL)) begin
                        win_d       = 1'b1;
                        game_over_d = 1'b1;
                        state_d     = ST_OVER;
                    end else begin
                        level_d = level_q + KEY_W'(1);
                        state_d = ST_GEN;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_FAIL: begin
                if (tmr_q == RESULT_LAST) begin
                    tmr_d     = '0;
                    key_idx_d = '0;
                    if (lives_q == 2'd0) begin
                        game_over_d = 1'b1;
                        state_d     = ST_OVER;
                    end else begin
                        state_d = ST_GEN;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output registers follow the next state so they line up with state_o.
        enable_d   = (state_d == ST_INPUT);
        time_up_d  = (state_d == ST_INPUT) &&
                     (time_up_q || ((state_q == ST_INPUT) && (tmr_q == TIMEOUT_LAST)));
        show_key_d = ((state_d == ST_SHOW) && !gap_d) ? target_d[{key_idx_d, 2'b00} +: KEY_W] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tmr_q         <= '0;
            key_idx_q     <= '0;
            gap_q         <= 1'b0;
            target_q      <= '0;
            level_q       <= KEY_W'(START_LEVEL);
            lives_q       <= 2'(LIVES_INIT);
            score_q       <= '0;
            win_q         <= 1'b0;
            game_over_q   <= 1'b0;
            timeout_q     <= 1'b0;
            enable_q      <= 1'b0;
            start_clear_q <= 1'b0;
            time_up_q     <= 1'b0;
            show_key_q    <= '0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            key_idx_q     <= key_idx_d;
            gap_q         <= gap_d;
            target_q      <= target_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            win_q         <= win_d;
            game_over_q   <= game_over_d;
            timeout_q     <= timeout_d;
            enable_q      <= enable_d;
            start_clear_q <= start_clear_d;
            time_up_q     <= time_up_d;
            show_key_q    <= show_key_d;
        end
    end

    assign enable_input = enable_q;
    assign start_clear  = start_clear_q;
    assign difficulty_k = level_q;
    assign time_up      = time_up_q;
    assign show_key     = show_key_q;
    assign state_o      = state_q;
    assign lives        = lives_q;
    assign score        = score_q;
    assign win          = win_q;
    assign game_over    = game_over_q;

endmodule
